// File: rtl/instr_encode_loader.sv
// instr_encode_loader: assembles symbolic MIPS instructions received over a
// valid/ready stream into 32-bit words and writes them sequentially into
// instruction memory, tracking word count, XOR checksum, done and overflow.
module instr_encode_loader #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [2:0]        op_sel,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [4:0]        shamt,
    input  logic [5:0]        funct,
    input  logic [15:0]       imm,
    input  logic [25:0]       target,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   count,
    output logic [31:0]       checksum,
    output logic              done,
    output logic              overflow
);

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StFull
    } state_t;

    // Operation select codes.
    localparam logic [2:0] OpLw   = 3'd0;
    localparam logic [2:0] OpSw   = 3'd1;
    localparam logic [2:0] OpRType = 3'd2;
    localparam logic [2:0] OpBeq  = 3'd3;
    localparam logic [2:0] OpAddi = 3'd4;
    localparam logic [2:0] OpAndi = 3'd5;
    localparam logic [2:0] OpOri  = 3'd6;
    localparam logic [2:0] OpJal  = 3'd7;

    // MIPS primary opcodes.
    localparam logic [5:0] OpcLw   = 6'b100011;
    localparam logic [5:0] OpcSw   = 6'b101011;
    localparam logic [5:0] OpcR    = 6'b000000;
    localparam logic [5:0] OpcBeq  = 6'b000100;
    localparam logic [5:0] OpcAddi = 6'b001000;
    localparam logic [5:0] OpcAndi = 6'b001100;
    localparam logic [5:0] OpcOri  = 6'b001101;
    localparam logic [5:0] OpcJal  = 6'b000011;

    localparam logic [ADDR_W-1:0] TopAddr  = '1;
    // Largest reachable word count: a full sweep of the address space.
    localparam logic [ADDR_W:0]   CountMax = {1'b1, {ADDR_W{1'b0}}};

    state_t            state_q;
    logic [ADDR_W-1:0] ptr_q;
    logic              accept;
    logic [31:0]       enc_word;

    assign in_ready = (state_q == StLoad);
    assign accept   = in_valid && in_ready;

    // Encode the beat currently on the input fields; unused fields are ignored.
    always_comb begin
        enc_word = '0;
        unique case (op_sel)
            OpLw:    enc_word = {OpcLw, rs, rt, imm};
            OpSw:    enc_word = {OpcSw, rs, rt, imm};
            OpRType: enc_word = {OpcR, rs, rt, rd, shamt, funct};
            OpBeq:   enc_word = {OpcBeq, rs, rt, imm};
            OpAddi:  enc_word = {OpcAddi, rs, rt, imm};
            OpAndi:  enc_word = {OpcAndi, rs, rt, imm};
            OpOri:   enc_word = {OpcOri, rs, rt, imm};
            OpJal:   enc_word = {OpcJal, target};
            default: enc_word = '0;
        endcase
    end

    // Load FSM with registered memory-write, status and bookkeeping outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            ptr_q      <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            count      <= '0;
            checksum   <= '0;
            done       <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            // Write strobe and done are single-cycle by default.
            imem_we <= 1'b0;
            done    <= 1'b0;
            unique case (state_q)
                StIdle, StFull: begin
                    if (start) begin
                        state_q  <= StLoad;
                        ptr_q    <= base_addr;
                        count    <= '0;
                        checksum <= '0;
                        overflow <= 1'b0;
                    end
                end
                StLoad: begin
                    // start is deliberately ignored while a load is running.
                    if (accept) begin
                        imem_we    <= 1'b1;
                        imem_addr  <= ptr_q;
                        imem_wdata <= enc_word;
                        checksum   <= checksum ^ enc_word;
                        if (count != CountMax) begin
                            count <= count + 1'b1;
                        end
                        ptr_q <= ptr_q + 1'b1;
                        if (in_last) begin
                            // A last beat at the top address still ends cleanly.
                            state_q <= StIdle;
                            done    <= 1'b1;
                        end else if (ptr_q == TopAddr) begin
                            state_q  <= StFull;
                            overflow <= 1'b1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_encode_loader.sv
// Self-checking bench for instr_encode_loader: a word-level reference model
// checks an ADDR_W=8 instance every cycle; an ADDR_W=4 instance covers the
// address-space boundary with literal expectations.
module tb_instr_encode_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic logic [31:0] encode(input logic [2:0] op, input logic [4:0] f_rs,
                                           input logic [4:0] f_rt, input logic [4:0] f_rd,
                                           input logic [4:0] f_sh, input logic [5:0] f_fn,
                                           input logic [15:0] f_im, input logic [25:0] f_tg);
        logic [5:0] opc;
        case (op)
            3'd0:    opc = 6'h23;
            3'd1:    opc = 6'h2B;
            3'd3:    opc = 6'h04;
            3'd4:    opc = 6'h08;
            3'd5:    opc = 6'h0C;
            3'd6:    opc = 6'h0D;
            default: opc = 6'h00;
        endcase
        if (op == 3'd2) return {6'h00, f_rs, f_rt, f_rd, f_sh, f_fn};
        if (op == 3'd7) return {6'h03, f_tg};
        return {opc, f_rs, f_rt, f_im};
    endfunction

    // ---------------- ADDR_W = 8 instance ----------------
    logic        rst, start, in_valid, in_ready, in_last;
    logic [7:0]  base_addr;
    logic [2:0]  op_sel;
    logic [4:0]  rs, rt, rd, shamt;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [25:0] target;
    logic        imem_we, done, overflow;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wdata, checksum;
    logic [8:0]  count;

    instr_encode_loader #(.ADDR_W(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .op_sel(op_sel), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
        .imm(imm), .target(target), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .count(count), .checksum(checksum), .done(done),
        .overflow(overflow)
    );

    // ---------------- ADDR_W = 4 instance ----------------
    logic        s_rst, s_start, s_valid, s_ready, s_last;
    logic [3:0]  s_base;
    logic [2:0]  s_op;
    logic [4:0]  s_rs, s_rt, s_rd, s_sh;
    logic [5:0]  s_fn;
    logic [15:0] s_im;
    logic [25:0] s_tg;
    logic        s_we, s_done, s_ovf;
    logic [3:0]  s_addr;
    logic [31:0] s_wdata, s_cks;
    logic [4:0]  s_cnt;

    instr_encode_loader #(.ADDR_W(4)) u_dut4 (
        .clk(clk), .rst(s_rst), .start(s_start), .base_addr(s_base),
        .in_valid(s_valid), .in_ready(s_ready), .in_last(s_last),
        .op_sel(s_op), .rs(s_rs), .rt(s_rt), .rd(s_rd), .shamt(s_sh), .funct(s_fn),
        .imm(s_im), .target(s_tg), .imem_we(s_we), .imem_addr(s_addr),
        .imem_wdata(s_wdata), .count(s_cnt), .checksum(s_cks), .done(s_done),
        .overflow(s_ovf)
    );

    // ---------------- reference model (ADDR_W = 8) ----------------
    // A load is described by its base and the number of words written so far;
    // every address, the count and the overflow point follow from those two.
    bit          m_on = 0, m_load = 0;
    int          m_base = 0, m_words = 0;
    logic [31:0] m_cks = '0, m_w;
    bit          e_we = 0, e_done = 0, e_ovf = 0;
    logic [7:0]  e_addr = '0;
    logic [31:0] e_wdata = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_on = 1; m_load = 0; m_base = 0; m_words = 0; m_cks = '0;
            e_we = 0; e_done = 0; e_ovf = 0; e_addr = '0; e_wdata = '0;
        end else if (m_on) begin
            e_we = 0; e_done = 0;
            if (!m_load) begin
                if (start) begin
                    m_load = 1; m_base = int'(base_addr); m_words = 0; m_cks = '0; e_ovf = 0;
                end
            end else if (in_valid) begin
                m_w     = encode(op_sel, rs, rt, rd, shamt, funct, imm, target);
                e_we    = 1;
                e_addr  = 8'((m_base + m_words) % 256);
                e_wdata = m_w;
                m_words++;
                m_cks  ^= m_w;
                e_done  = in_last;
                if (in_last) m_load = 0;
                else if (m_base + m_words == 256) begin
                    m_load = 0; e_ovf = 1;
                end
            end
        end
    end

    // Per-cycle comparison plus a log of observed writes for literal checks.
    logic [39:0] wlog[$];
    int          done_cnt = 0;

    always @(negedge clk) begin
        if (m_on) begin
            check("in_ready", 64'(in_ready), 64'(m_load));
            check("imem_we", 64'(imem_we), 64'(e_we));
            check("imem_addr", 64'(imem_addr), 64'(e_addr));
            check("imem_wdata", 64'(imem_wdata), 64'(e_wdata));
            check("count", 64'(count), 64'(m_words));
            check("checksum", 64'(checksum), 64'(m_cks));
            check("done", 64'(done), 64'(e_done));
            check("overflow", 64'(overflow), 64'(e_ovf));
            if (imem_we) wlog.push_back({imem_addr, imem_wdata});
            if (done) done_cnt++;
        end
    end

    task automatic beat8(input logic [2:0] op, input logic [4:0] f_rs, input logic [4:0] f_rt,
                         input logic [4:0] f_rd, input logic [5:0] f_fn, input logic [15:0] f_im,
                         input logic [25:0] f_tg, input logic last);
        in_valid = 1'b1; in_last = last; op_sel = op;
        rs = f_rs; rt = f_rt; rd = f_rd; shamt = 5'($urandom); funct = f_fn;
        imm = f_im; target = f_tg;
    endtask

    task automatic rand_fields8();
        op_sel = 3'($urandom); rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom);
        shamt = 5'($urandom); funct = 6'($urandom); imm = 16'($urandom);
        target = 26'($urandom);
    endtask

    task automatic rand_fields4();
        s_op = 3'($urandom); s_rs = 5'($urandom); s_rt = 5'($urandom); s_rd = 5'($urandom);
        s_sh = 5'($urandom); s_fn = 6'($urandom); s_im = 16'($urandom);
        s_tg = 26'($urandom);
    endtask

    function automatic logic [31:0] s_enc();
        return encode(s_op, s_rs, s_rt, s_rd, s_sh, s_fn, s_im, s_tg);
    endfunction

    logic [31:0] s_w;

    initial begin
        rst = 1; start = 0; base_addr = '0; in_valid = 0; in_last = 0; rand_fields8();
        s_rst = 1; s_start = 0; s_base = '0; s_valid = 0; s_last = 0; rand_fields4();
        repeat (2) @(negedge clk);
        // Reset state.
        check("rst_we", 64'(imem_we), 64'(0));
        check("rst_count", 64'(count), 64'(0));
        check("rst_ready", 64'(s_ready), 64'(0));
        rst = 0; s_rst = 0;

        // Program at base 0x10; unused fields carry junk that must be ignored.
        wlog.delete(); done_cnt = 0;
        @(negedge clk); start = 1; base_addr = 8'h10;
        @(negedge clk); start = 0;
        beat8(3'd4, 5'd0, 5'd8, 5'd17, 6'h3F, 16'h0005, 26'h3ABCDEF, 1'b0);
        @(negedge clk); beat8(3'd0, 5'd8, 5'd9, 5'd3, 6'h11, 16'h0004, 26'h1234567, 1'b0);
        @(negedge clk); beat8(3'd2, 5'd8, 5'd9, 5'd10, 6'h20, 16'hBEEF, 26'h2222222, 1'b0);
        shamt = 5'd0;
        @(negedge clk); beat8(3'd3, 5'd8, 5'd9, 5'd31, 6'h2A, 16'hFFFE, 26'h0F0F0F0, 1'b0);
        @(negedge clk); beat8(3'd7, 5'd21, 5'd7, 5'd2, 6'h05, 16'h5555, 26'h0000010, 1'b1);
        @(negedge clk); in_valid = 0; in_last = 0;
        check("prog_done", 64'(done), 64'(1));
        check("prog_count", 64'(count), 64'(5));
        check("prog_checksum", 64'(checksum), 64'(32'hB101AFCF));
        @(negedge clk);
        check("prog_done_clear", 64'(done), 64'(0));
        check("prog_nwrites", 64'(wlog.size()), 64'(5));
        check("prog_ndone", 64'(done_cnt), 64'(1));
        if (wlog.size() == 5) begin
            check("prog_w0", 64'(wlog[0]), 64'({8'h10, 32'h20080005}));
            check("prog_w1", 64'(wlog[1]), 64'({8'h11, 32'h8D090004}));
            check("prog_w2", 64'(wlog[2]), 64'({8'h12, 32'h01095020}));
            check("prog_w3", 64'(wlog[3]), 64'({8'h13, 32'h1109FFFE}));
            check("prog_w4", 64'(wlog[4]), 64'({8'h14, 32'h0C000010}));
        end

        // start pulsed mid-load is ignored.
        @(negedge clk); start = 1; base_addr = 8'h20;
        @(negedge clk); start = 0; rand_fields8(); in_valid = 1; in_last = 0;
        @(negedge clk); rand_fields8(); start = 1; base_addr = 8'h80;
        @(negedge clk); rand_fields8(); start = 0; in_last = 1;
        @(negedge clk); in_valid = 0; in_last = 0;
        check("ign_start_addr", 64'(imem_addr), 64'(8'h22));
        check("ign_start_count", 64'(count), 64'(3));

        // Reset in the cycle after an accepted beat.
        @(negedge clk); start = 1; base_addr = 8'h40;
        @(negedge clk); start = 0; rand_fields8(); in_valid = 1;
        @(negedge clk); rst = 1;
        check("pre_rst_we", 64'(imem_we), 64'(1));
        @(negedge clk); rst = 0;
        check("rst_mid_we", 64'(imem_we), 64'(0));
        check("rst_mid_count", 64'(count), 64'(0));
        check("rst_mid_addr", 64'(imem_addr), 64'(0));
        repeat (2) @(negedge clk);
        check("rst_mid_ready", 64'(in_ready), 64'(0));
        in_valid = 0;

        // ADDR_W=4: base 14, three beats without last.
        @(negedge clk); s_start = 1; s_base = 4'd14;
        @(negedge clk); s_start = 0; rand_fields4(); s_valid = 1; s_last = 0; s_w = s_enc();
        @(negedge clk);
        check("d4_we14", 64'(s_we), 64'(1));
        check("d4_addr14", 64'(s_addr), 64'(14));
        check("d4_data14", 64'(s_wdata), 64'(s_w));
        check("d4_ovf14", 64'(s_ovf), 64'(0));
        rand_fields4(); s_w = s_enc();
        @(negedge clk);
        check("d4_addr15", 64'(s_addr), 64'(15));
        check("d4_data15", 64'(s_wdata), 64'(s_w));
        check("d4_ovf_set", 64'(s_ovf), 64'(1));
        check("d4_ready_full", 64'(s_ready), 64'(0));
        rand_fields4();
        @(negedge clk);
        check("d4_third_we", 64'(s_we), 64'(0));
        check("d4_full_count", 64'(s_cnt), 64'(2));
        s_valid = 0; s_start = 1; s_base = 4'd3;
        @(negedge clk); s_start = 0;
        check("d4_restart_ovf", 64'(s_ovf), 64'(0));
        check("d4_restart_ready", 64'(s_ready), 64'(1));
        check("d4_restart_count", 64'(s_cnt), 64'(0));
        rand_fields4(); s_valid = 1; s_last = 1;
        @(negedge clk); s_valid = 0; s_last = 0;
        check("d4_addr3", 64'(s_addr), 64'(3));
        check("d4_done3", 64'(s_done), 64'(1));

        // ADDR_W=4: base 15, single last beat at the top address.
        @(negedge clk); s_start = 1; s_base = 4'd15;
        @(negedge clk); s_start = 0; rand_fields4(); s_valid = 1; s_last = 1; s_w = s_enc();
        @(negedge clk); s_valid = 0; s_last = 0;
        check("d4_top_we", 64'(s_we), 64'(1));
        check("d4_top_addr", 64'(s_addr), 64'(15));
        check("d4_top_done", 64'(s_done), 64'(1));
        check("d4_top_ovf", 64'(s_ovf), 64'(0));
        check("d4_top_cks", 64'(s_cks), 64'(s_w));
        @(negedge clk);
        check("d4_top_idle", 64'(s_ready), 64'(0));
        check("d4_top_done_clr", 64'(s_done), 64'(0));

        // Randomized traffic on the ADDR_W=8 instance, checked by the model.
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            rst       = ($urandom % 300) == 0;
            start     = ($urandom % 12) == 0;
            base_addr = (($urandom % 3) == 0) ? 8'(8'hF8 + ($urandom % 8)) : 8'($urandom);
            in_valid  = ($urandom % 4) != 0;
            in_last   = ($urandom % 12) == 0;
            rand_fields8();
        end
        @(negedge clk); rst = 0; start = 0; in_valid = 0;
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
